// File: rtl/k10_pmp_checker.sv
// k10_pmp_checker: registered, handshaked PMP checker with a configurable
// physical-address width and region granularity. It checks multi-byte
// accesses, denies partial matches, waits one settle cycle after a config
// write, and keeps the address of the first denied response.

package k10_pmp_pkg;
    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_lvl_e;
endpackage

module k10_pmp_checker
    import k10_pmp_pkg::*;
#(
    parameter int PMP_REGIONS = 16,
    parameter int PMP_GRAN    = 0,
    parameter int PA_WIDTH    = 34,
    localparam int RW = (PMP_REGIONS > 1) ? $clog2(PMP_REGIONS) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [PMP_REGIONS-1:0][7:0]       i_pmp_cfg,
    input  logic [PMP_REGIONS-1:0][31:0]      i_pmp_addr,
    input  logic                              i_cfg_wr,
    input  logic                              i_req_valid,
    output logic                              o_req_ready,
    input  logic [PA_WIDTH-1:0]               i_req_addr,
    input  logic [1:0]                        i_req_size,
    input  priv_lvl_e                         i_req_priv,
    input  logic                              i_req_read,
    input  logic                              i_req_write,
    input  logic                              i_req_exec,
    output logic                              o_rsp_valid,
    input  logic                              i_rsp_ready,
    output logic                              o_rsp_allowed,
    output logic                              o_rsp_hit,
    output logic [RW-1:0]                     o_rsp_region,
    output logic                              o_fault_valid,
    output logic [PA_WIDTH-1:0]               o_fault_addr,
    input  logic                              i_fault_clr
);

    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    // With G>=1, the low G pmpaddr bits read as zero for TOR.
    localparam logic [31:0] TOR_MASK =
        (PMP_GRAN >= 1) ? ~((32'd1 << PMP_GRAN) - 32'd1) : 32'hFFFF_FFFF;
    // With G>=2, the low G-1 pmpaddr bits read as one for NAPOT.
    localparam logic [31:0] NAPOT_ONES =
        (PMP_GRAN >= 2) ? ((32'd1 << ((PMP_GRAN >= 2) ? PMP_GRAN - 1 : 0)) - 32'd1) : 32'd0;

    typedef enum logic {
        ST_RUN,
        ST_SETTLE
    } state_e;

    // Match one word address against one region; prev_raw is the pmpaddr below it.
    function automatic logic addr_match(input logic [1:0]  mode,
                                        input logic [31:0] pa_raw,
                                        input logic [31:0] prev_raw,
                                        input logic [31:0] aw);
        logic [31:0] top;
        logic [31:0] bot;
        logic [31:0] pa_napot;
        logic [31:0] care;
        logic        m;
        top      = pa_raw & TOR_MASK;
        bot      = prev_raw & TOR_MASK;
        pa_napot = pa_raw | NAPOT_ONES;
        // The trailing ones and the zero above them are don't-care bits.
        care     = ~(pa_napot ^ (pa_napot + 32'd1));
        m        = 1'b0;
        case (mode)
            A_TOR:   m = (aw >= bot) && (aw < top);
            A_NA4:   m = (PMP_GRAN == 0) && (aw == pa_raw);
            A_NAPOT: m = ((aw ^ pa_napot) & care) == 32'd0;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    state_e               state_q;
    logic                 rsp_valid_q;
    logic                 rsp_allowed_q;
    logic                 rsp_hit_q;
    logic [RW-1:0]        rsp_region_q;
    logic [PA_WIDTH-1:0]  rsp_addr_q;
    logic                 fault_valid_q;
    logic [PA_WIDTH-1:0]  fault_addr_q;

    logic                 rsp_allowed_d;
    logic                 rsp_hit_d;
    logic [RW-1:0]        rsp_region_d;

    logic [PA_WIDTH:0]    last_byte;
    logic [PA_WIDTH:0]    span_m1;
    logic [31:0]          aw_first;
    logic [31:0]          aw_last;
    logic [31:0]          prev_addr;
    logic                 bad_range;
    logic                 found;
    logic                 partial;
    logic                 mf;
    logic                 ml;
    logic                 perm_ok;
    logic [7:0]           dec_cfg;
    logic                 unused_bits;

    logic                 accept;
    logic                 rsp_fire;

    assign o_req_ready = (state_q == ST_RUN) && !i_cfg_wr && (!rsp_valid_q || i_rsp_ready);
    assign accept      = i_req_valid && o_req_ready;
    assign rsp_fire    = rsp_valid_q && i_rsp_ready;

    // Combinational check of the presented request against the current config.
    always_comb begin
        span_m1 = '0;
        case (i_req_size)
            2'd1:    span_m1[1:0] = 2'd1;
            2'd2:    span_m1[1:0] = 2'd3;
            default: span_m1[1:0] = 2'd0;
        endcase
        last_byte   = {1'b0, i_req_addr} + span_m1;
        bad_range   = last_byte[PA_WIDTH] || (i_req_size == 2'd3);
        aw_first    = 32'(i_req_addr[PA_WIDTH-1:2]);
        aw_last     = 32'(last_byte[PA_WIDTH-1:2]);
        prev_addr   = 32'd0;
        found       = 1'b0;
        partial     = 1'b0;
        dec_cfg     = 8'd0;
        rsp_region_d = '0;
        unused_bits = ^{i_req_addr[1:0], last_byte[1:0]};
        for (int i = 0; i < PMP_REGIONS; i++) begin
            mf = addr_match(i_pmp_cfg[i][4:3], i_pmp_addr[i], prev_addr, aw_first);
            ml = addr_match(i_pmp_cfg[i][4:3], i_pmp_addr[i], prev_addr, aw_last);
            if (!found && (mf || ml)) begin
                found        = 1'b1;
                partial      = mf ^ ml;
                dec_cfg      = i_pmp_cfg[i];
                rsp_region_d = RW'(i);
            end
            prev_addr   = i_pmp_addr[i];
            unused_bits = unused_bits ^ (^i_pmp_cfg[i][6:5]);
        end
        perm_ok = (!i_req_read  || dec_cfg[0]) &&
                  (!i_req_write || dec_cfg[1]) &&
                  (!i_req_exec  || dec_cfg[2]);
        if (bad_range) begin
            rsp_allowed_d = 1'b0;
            rsp_hit_d     = 1'b0;
            rsp_region_d  = '0;
        end else if (found) begin
            rsp_hit_d = 1'b1;
            if (partial)
                rsp_allowed_d = 1'b0;
            else if (i_req_priv == PRIV_M)
                rsp_allowed_d = !dec_cfg[7] || perm_ok;
            else
                rsp_allowed_d = perm_ok;
        end else begin
            rsp_hit_d     = 1'b0;
            rsp_allowed_d = (i_req_priv == PRIV_M);
        end
    end

    // Config-update FSM: any cfg write forces one settle cycle before accepting.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= ST_RUN;
        else if (i_cfg_wr)
            state_q <= ST_SETTLE;
        else
            state_q <= ST_RUN;
    end

    // Response register: load on accept, hold until consumed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_allowed_q <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_region_q  <= '0;
            rsp_addr_q    <= '0;
        end else if (accept) begin
            rsp_valid_q   <= 1'b1;
            rsp_allowed_q <= rsp_allowed_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_region_q  <= rsp_region_d;
            rsp_addr_q    <= i_req_addr;
        end else if (rsp_fire) begin
            rsp_valid_q   <= 1'b0;
        end
    end

    // Sticky first-fault capture; a coincident clear loses to a new denial.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else if (rsp_fire && !rsp_allowed_q && (!fault_valid_q || i_fault_clr)) begin
            fault_valid_q <= 1'b1;
            fault_addr_q  <= rsp_addr_q;
        end else if (i_fault_clr) begin
            fault_valid_q <= 1'b0;
        end
    end

    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_allowed = rsp_allowed_q;
    assign o_rsp_hit     = rsp_hit_q;
    assign o_rsp_region  = rsp_region_q;
    assign o_fault_valid = fault_valid_q;
    assign o_fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_k10_pmp_checker.sv
// Scoreboard bench for k10_pmp_checker: directed requests push expected
// responses; a monitor pops and compares on each response handshake.
module tb_k10_pmp_checker;
    import k10_pmp_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0][7:0]   cfg = '0;
    logic [15:0][31:0]  pa  = '0;
    logic               cfg_wr = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [33:0]        req_addr = '0;
    logic [1:0]         req_size = '0;
    priv_lvl_e          req_priv = PRIV_M;
    logic               req_read = 1'b0;
    logic               req_write = 1'b0;
    logic               req_exec = 1'b0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic               rsp_allowed;
    logic               rsp_hit;
    logic [3:0]         rsp_region;
    logic               fault_valid;
    logic [33:0]        fault_addr;
    logic               fault_clr = 1'b0;

    typedef struct {
        logic       a;
        logic       h;
        logic [3:0] r;
        string      nm;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    k10_pmp_checker #(.PMP_REGIONS(16), .PMP_GRAN(0), .PA_WIDTH(34)) dut (
        .i_clk(clk), .i_rst(rst), .i_pmp_cfg(cfg), .i_pmp_addr(pa),
        .i_cfg_wr(cfg_wr), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_size(req_size), .i_req_priv(req_priv),
        .i_req_read(req_read), .i_req_write(req_write), .i_req_exec(req_exec),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_allowed(rsp_allowed), .o_rsp_hit(rsp_hit), .o_rsp_region(rsp_region),
        .o_fault_valid(fault_valid), .o_fault_addr(fault_addr), .i_fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: compare on every response handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got {a,h,r}=%b%b%0d, expected none",
                         rsp_allowed, rsp_hit, rsp_region);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.nm, 64'({rsp_allowed, rsp_hit, rsp_region}), 64'({e.a, e.h, e.r}));
            end
        end
    end

    // Present one request; returns at posedge+1 after it was accepted.
    task automatic issue(input logic [33:0] a, input logic [1:0] sz, input priv_lvl_e p,
                         input logic r, input logic w, input logic x,
                         input logic ea, input logic eh, input logic [3:0] er, input string nm);
        int cyc;
        exp_t e;
        req_addr = a; req_size = sz; req_priv = p;
        req_read = r; req_write = w; req_exec = x;
        req_valid = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_accept_timeout: got ready=0, expected ready=1", nm);
        end else begin
            e.a = ea; e.h = eh; e.r = er; e.nm = nm;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Wait until every expected response has been consumed.
    task automatic drain(input string nm);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while ((sb.size() != 0 || rsp_valid) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() != 0 || rsp_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_drain_timeout: got %0d pending, expected 0", nm, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic set_region(input int idx, input logic [7:0] c, input logic [31:0] a);
        cfg[idx] = c;
        pa[idx]  = a;
        cfg_wr   = 1'b1;
        @(posedge clk); #1;
        cfg_wr   = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_fields", 64'({rsp_allowed, rsp_hit, rsp_region}), 64'd0);
        chk("reset_fault_valid", 64'(fault_valid), 64'd0);
        chk("reset_fault_addr", 64'(fault_addr), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // All regions OFF
        issue(34'h3_FFFF_FFFC, 2'd2, PRIV_M, 1, 0, 0, 1, 0, 0, "off_m_read");
        issue(34'h3_FFFF_FFFC, 2'd2, PRIV_U, 1, 0, 0, 0, 0, 0, "off_u_read");
        drain("off");
        chk("off_fault_valid", 64'(fault_valid), 64'd1);
        chk("off_fault_addr", 64'(fault_addr), 64'h3_FFFF_FFFC);
        issue(34'h3_FFFF_FFFE, 2'd2, PRIV_M, 1, 0, 0, 0, 0, 0, "overflow_m_word");
        issue(34'h0_0000_0000, 2'd3, PRIV_M, 1, 0, 0, 0, 0, 0, "size3_m");
        drain("overflow");
        chk("sticky_fault_addr", 64'(fault_addr), 64'h3_FFFF_FFFC);
        fault_clr = 1'b1;
        @(posedge clk); #1;
        fault_clr = 1'b0;
        chk("fault_clear", 64'(fault_valid), 64'd0);

        // Region0 NAPOT, R only
        set_region(0, 8'h19, 32'h0000_01FF);
        issue(34'h7FC, 2'd2, PRIV_U, 1, 0, 0, 1, 1, 0, "napot_u_read");
        issue(34'h100, 2'd0, PRIV_U, 0, 1, 0, 0, 1, 0, "napot_u_write");
        drain("napot");
        chk("napot_fault_valid", 64'(fault_valid), 64'd1);
        chk("napot_fault_addr", 64'(fault_addr), 64'h100);
        issue(34'h104, 2'd0, PRIV_U, 0, 1, 0, 0, 1, 0, "deny_b2b_1");
        issue(34'h108, 2'd0, PRIV_U, 0, 1, 0, 0, 1, 0, "deny_b2b_2");
        drain("b2b");
        chk("b2b_fault_addr", 64'(fault_addr), 64'h100);

        // Clear coincident with a new denial handshake
        rsp_ready = 1'b0;
        issue(34'h300, 2'd0, PRIV_U, 0, 1, 0, 0, 1, 0, "deny_clr");
        fault_clr = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        fault_clr = 1'b0;
        chk("clr_race_fault_valid", 64'(fault_valid), 64'd1);
        chk("clr_race_fault_addr", 64'(fault_addr), 64'h300);

        // Region0 TOR RWX, top 0x1000
        set_region(0, 8'h0F, 32'h0000_0400);
        issue(34'hFFE, 2'd2, PRIV_U, 1, 0, 0, 0, 1, 0, "tor_partial_u");
        issue(34'hFFE, 2'd2, PRIV_M, 1, 0, 0, 0, 1, 0, "tor_partial_m");
        issue(34'hFF8, 2'd2, PRIV_U, 1, 0, 0, 1, 1, 0, "tor_full_u");
        issue(34'hFFE, 2'd1, PRIV_U, 0, 1, 0, 1, 1, 0, "tor_half_top");
        issue(34'h1000, 2'd2, PRIV_U, 1, 0, 0, 0, 0, 0, "tor_above_u");
        drain("tor");

        // Region2 NAPOT 4KB at 0x8000_0000, locked, RW only
        set_region(0, 8'h00, 32'h0);
        set_region(2, 8'h9B, 32'h2000_01FF);
        issue(34'h8000_0010, 2'd2, PRIV_M, 0, 0, 1, 0, 1, 2, "locked_m_exec");
        drain("locked");
        set_region(2, 8'h1B, 32'h2000_01FF);
        issue(34'h8000_0010, 2'd2, PRIV_M, 0, 0, 1, 1, 1, 2, "unlocked_m_exec");
        issue(34'h8000_0010, 2'd2, PRIV_U, 0, 0, 1, 0, 1, 2, "unlocked_u_exec");
        issue(34'h8000_0010, 2'd2, PRIV_U, 1, 0, 0, 1, 1, 2, "unlocked_u_read");
        drain("unlocked");

        // Response backpressure
        rsp_ready = 1'b0;
        issue(34'h8000_0000, 2'd2, PRIV_M, 1, 0, 0, 1, 1, 2, "bp_first");
        req_addr = 34'h8000_0004; req_size = 2'd2; req_priv = PRIV_U;
        req_read = 1'b1; req_write = 1'b0; req_exec = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_rsp_hold", 64'({rsp_valid, rsp_allowed, rsp_hit, rsp_region}), 64'b1_1_1_0010);
        end
        @(posedge clk); #1;
        begin
            exp_t e;
            e.a = 1; e.h = 1; e.r = 2; e.nm = "bp_second";
            sb.push_back(e);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain("bp");

        // Config write settle window
        req_addr = 34'h8000_0008; req_size = 2'd2; req_priv = PRIV_U;
        req_read = 1'b1; req_write = 1'b0; req_exec = 1'b0;
        req_valid = 1'b1;
        cfg_wr = 1'b1;
        @(negedge clk);
        chk("cfgwr_ready_c0", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        @(negedge clk);
        chk("cfgwr_ready_c1", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cfgwr_ready_c2", 64'(req_ready), 64'd1);
        begin
            exp_t e;
            e.a = 1; e.h = 1; e.r = 2; e.nm = "settle_req";
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain("settle");

        // Reset with a response pending
        rsp_ready = 1'b0;
        issue(34'h8000_0010, 2'd2, PRIV_M, 1, 0, 0, 1, 1, 2, "pre_reset");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_fields", 64'({rsp_allowed, rsp_hit, rsp_region}), 64'd0);
        chk("rst_fault_valid", 64'(fault_valid), 64'd0);
        chk("rst_fault_addr", 64'(fault_addr), 64'd0);
        rsp_ready = 1'b1;
        issue(34'h8000_0010, 2'd2, PRIV_M, 1, 0, 0, 1, 1, 2, "post_reset");
        drain("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
